// File: rtl/distributor_stim.sv
// Scripted slice transmitter: replays a fixed golden table of beats, one lane-tagged beat at a time.
// Optional build macro STIM_ERR_INJECT_EN flips data_out bit 0 on beat 3 to exercise checker failures.
module distributor_stim #(
  parameter int NUM_BEATS  = 6,
  parameter int GAP_CYCLES = 0,
  parameter int LANES      = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LANES-1:0] lane_ready,
  output logic [143:0]     data_out,
  output logic [15:0]      token_pos,
  output logic [16:0]      address,
  output logic [2:0]       garbage,
  output logic             start_lit,
  output logic [LANES-1:0] valid,
  output logic [3:0]       beat_cnt,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state_dbg
);
  // Handshake: a beat transfers on a rising edge where |(valid & lane_ready); until then valid and
  // every payload field hold steady. Ready bits of non-targeted lanes never cause a transfer.

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_GAP, S_DONE} state_t;

  typedef struct packed {
    logic [143:0] data;
    logic [15:0]  tok;
    logic [16:0]  addr;
    logic [2:0]   garb;
    logic         lit;
  } beat_t;

  localparam int          LW        = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);
  localparam logic [3:0]  LAST_IDX  = 4'(NUM_BEATS - 1);
  localparam logic [7:0]  GAP_LAST  = 8'(GAP_CYCLES - 1);

  function automatic beat_t golden(input logic [3:0] i);
    beat_t b;
    case (i)
      4'd0: b = {144'h040d0a090200203a01007c414c4943000000, 16'h9520, 17'h00000, 3'd3, 1'b0};
      4'd1: b = {144'h494345275320414456454e54555245532049, 16'h0000, 17'h0001a, 3'd0, 1'b1};
      4'd2: b = {144'h20494e20574f4e4445524c414e4401363e34, 16'h0002, 17'h0002a, 3'd0, 1'b1};
      4'd3: b = {144'h3e34001944304c6577697320436172726f6c, 16'h9400, 17'h0003c, 3'd0, 1'b0};
      4'd4: b = {144'h6f6c6c01613a5f0088544845204d494c4c45, 16'h1480, 17'h00060, 3'd0, 1'b1};
      4'd5: b = {144'h4c454e4e49554d2046554c4352554d204544, 16'h0000, 17'h0007d, 3'd0, 1'b1};
      default: b = '0;
    endcase
`ifdef STIM_ERR_INJECT_EN
    if (i == 4'd3) b.data[0] = ~b.data[0];
`else
`endif
    return b;
  endfunction

  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [LW-1:0] lane_q, lane_d;
  logic [3:0]    beat_q, beat_d;
  logic [7:0]    gap_q, gap_d;
  beat_t         payload_q, payload_d;
  logic [LANES-1:0] valid_w;
  logic          accept;

  always_comb begin
    for (int k = 0; k < LANES; k++) valid_w[k] = (state_q == S_SEND) && (lane_q == LW'(k));
  end

  assign accept = |(valid_w & lane_ready);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    lane_d    = lane_q;
    beat_d    = beat_q;
    gap_d     = gap_q;
    payload_d = payload_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          idx_d   = '0;
          lane_d  = '0;
          beat_d  = '0;
        end
      end
      S_LOAD: begin
        payload_d = golden(idx_q);
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (accept) begin
          beat_d = beat_q + 4'd1;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d  = idx_q + 4'd1;
            lane_d = (lane_q == LANE_LAST) ? '0 : lane_q + 1'b1;
            if (GAP_CYCLES == 0) begin
              payload_d = golden(idx_q + 4'd1);
            end else if (GAP_CYCLES == 1) begin
              state_d = S_LOAD;
            end else begin
              state_d = S_GAP;
              gap_d   = 8'd1;
            end
          end
        end
      end
      S_GAP: begin
        // LOAD is itself the final idle cycle of the gap
        if (gap_q == GAP_LAST) state_d = S_LOAD;
        else gap_d = gap_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      lane_q    <= '0;
      beat_q    <= '0;
      gap_q     <= '0;
      payload_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      lane_q    <= lane_d;
      beat_q    <= beat_d;
      gap_q     <= gap_d;
      payload_q <= payload_d;
    end
  end

  // Payload is masked whenever no beat is offered so downstream never sees stale data
  assign valid     = valid_w;
  assign data_out  = (state_q == S_SEND) ? payload_q.data : '0;
  assign token_pos = (state_q == S_SEND) ? payload_q.tok  : '0;
  assign address   = (state_q == S_SEND) ? payload_q.addr : '0;
  assign garbage   = (state_q == S_SEND) ? payload_q.garb : '0;
  assign start_lit = (state_q == S_SEND) ? payload_q.lit  : 1'b0;
  assign beat_cnt  = beat_q;
  assign busy      = (state_q == S_LOAD) || (state_q == S_SEND) || (state_q == S_GAP);
  assign done      = (state_q == S_DONE);
  assign state_dbg = state_q;
endmodule

// File: tb/tb_distributor_stim.sv
// Directed bench for distributor_stim: back-to-back instance plus a GAP_CYCLES=2 instance.
module tb_distributor_stim;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, start_g = 1'b0;
  logic [5:0] ready = '0, ready_g = '0;

  logic [143:0] data_out, data_out_g;
  logic [15:0]  token_pos, token_pos_g;
  logic [16:0]  address, address_g;
  logic [2:0]   garbage, garbage_g;
  logic         start_lit, start_lit_g;
  logic [5:0]   valid, valid_g;
  logic [3:0]   beat_cnt, beat_cnt_g;
  logic         busy, busy_g, done, done_g;
  logic [2:0]   state_dbg, state_dbg_g;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  distributor_stim #(.NUM_BEATS(6), .GAP_CYCLES(0), .LANES(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .lane_ready(ready),
    .data_out(data_out), .token_pos(token_pos), .address(address), .garbage(garbage),
    .start_lit(start_lit), .valid(valid), .beat_cnt(beat_cnt), .busy(busy), .done(done),
    .state_dbg(state_dbg));

  distributor_stim #(.NUM_BEATS(6), .GAP_CYCLES(2), .LANES(6)) dut_g (
    .clk(clk), .rst_n(rst_n), .start(start_g), .lane_ready(ready_g),
    .data_out(data_out_g), .token_pos(token_pos_g), .address(address_g), .garbage(garbage_g),
    .start_lit(start_lit_g), .valid(valid_g), .beat_cnt(beat_cnt_g), .busy(busy_g), .done(done_g),
    .state_dbg(state_dbg_g));

  function automatic logic [180:0] exp_beat(input int i);
    logic [180:0] b;
    case (i)
      0: b = {144'h040d0a090200203a01007c414c4943000000, 16'h9520, 17'h00000, 3'd3, 1'b0};
      1: b = {144'h494345275320414456454e54555245532049, 16'h0000, 17'h0001a, 3'd0, 1'b1};
      2: b = {144'h20494e20574f4e4445524c414e4401363e34, 16'h0002, 17'h0002a, 3'd0, 1'b1};
      3: b = {144'h3e34001944304c6577697320436172726f6c, 16'h9400, 17'h0003c, 3'd0, 1'b0};
      4: b = {144'h6f6c6c01613a5f0088544845204d494c4c45, 16'h1480, 17'h00060, 3'd0, 1'b1};
      5: b = {144'h4c454e4e49554d2046554c4352554d204544, 16'h0000, 17'h0007d, 3'd0, 1'b1};
      default: b = '0;
    endcase
`ifdef STIM_ERR_INJECT_EN
    if (i == 3) b[37] = ~b[37];
`else
`endif
    return b;
  endfunction

  function automatic logic [180:0] pay();
    return {data_out, token_pos, address, garbage, start_lit};
  endfunction

  function automatic logic [180:0] pay_g();
    return {data_out_g, token_pos_g, address_g, garbage_g, start_lit_g};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 64 && done !== 1'b1; k++) tick();
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL %s_done: got %b expected 1", name, done); end
    checks++;
    if (beat_cnt !== 4'd6) begin errors++; $display("FAIL %s_cnt: got %0d expected 6", name, beat_cnt); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; ready = '0;
    repeat (2) tick();
    checks++;
    if ({valid, busy, done, beat_cnt} !== 12'd0 || pay() !== 181'd0) begin
      errors++; $display("FAIL reset: got valid=%h busy=%b done=%b cnt=%0d expected all 0", valid, busy, done, beat_cnt);
    end
    checks++;
    if ({valid_g, busy_g, done_g, beat_cnt_g} !== 12'd0 || pay_g() !== 181'd0) begin
      errors++; $display("FAIL reset_gap: got valid=%h busy=%b expected 0", valid_g, busy_g);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_run();
    logic [5:0] ev;
    ready = 6'h3f; start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (valid !== 6'h00 || busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL load: got valid=%h busy=%b done=%b expected 00/1/0", valid, busy, done);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      ev = 6'b1 << i;
      checks++;
      if (valid !== ev) begin errors++; $display("FAIL run_valid%0d: got %h expected %h", i, valid, ev); end
      checks++;
      if (pay() !== exp_beat(i)) begin errors++; $display("FAIL run_pay%0d: got %h expected %h", i, pay(), exp_beat(i)); end
    end
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || beat_cnt !== 4'd6 || valid !== 6'h00 || pay() !== 181'd0) begin
      errors++; $display("FAIL run_end: got done=%b busy=%b cnt=%0d valid=%h expected 1/0/6/00", done, busy, beat_cnt, valid);
    end
  endtask

  task automatic test_stall();
    ready = 6'h00; start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (valid !== 6'h01 || pay() !== exp_beat(0) || beat_cnt !== 4'd0) begin
        errors++; $display("FAIL stall%0d: got valid=%h addr=%h cnt=%0d expected 01/00000/0", k, valid, address, beat_cnt);
      end
    end
    ready = 6'h3f; tick();
    checks++;
    if (valid !== 6'h02 || beat_cnt !== 4'd1 || pay() !== exp_beat(1)) begin
      errors++; $display("FAIL stall_release: got valid=%h cnt=%0d expected 02/1", valid, beat_cnt);
    end
    wait_done("stall");
  endtask

  task automatic test_non_target();
    ready = 6'h3e; start = 1'b1; tick(); start = 1'b0;
    repeat (3) begin
      tick();
      checks++;
      if (valid !== 6'h01 || beat_cnt !== 4'd0) begin
        errors++; $display("FAIL nontarget_hold: got valid=%h cnt=%0d expected 01/0", valid, beat_cnt);
      end
    end
    ready = 6'h01; tick();
    checks++;
    if (valid !== 6'h02 || beat_cnt !== 4'd1) begin
      errors++; $display("FAIL nontarget_lane0: got valid=%h cnt=%0d expected 02/1", valid, beat_cnt);
    end
    tick();
    checks++;
    if (valid !== 6'h02 || beat_cnt !== 4'd1) begin
      errors++; $display("FAIL nontarget_lane1: got valid=%h cnt=%0d expected 02/1", valid, beat_cnt);
    end
    ready = 6'h3f;
    wait_done("nontarget");
  endtask

  task automatic test_gap();
    logic [5:0] ev;
    ready_g = 6'h3f; start_g = 1'b1; tick(); start_g = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      ev = 6'b1 << i;
      checks++;
      if (valid_g !== ev || pay_g() !== exp_beat(i)) begin
        errors++; $display("FAIL gap_beat%0d: got valid=%h pay=%h expected %h/%h", i, valid_g, pay_g(), ev, exp_beat(i));
      end
      if (i < 5) begin
        for (int g = 0; g < 2; g++) begin
          tick();
          checks++;
          if (valid_g !== 6'h00 || pay_g() !== 181'd0 || busy_g !== 1'b1) begin
            errors++; $display("FAIL gap_idle%0d_%0d: got valid=%h busy=%b expected 00/1", i, g, valid_g, busy_g);
          end
        end
      end
    end
    tick();
    checks++;
    if (done_g !== 1'b1 || beat_cnt_g !== 4'd6) begin
      errors++; $display("FAIL gap_end: got done=%b cnt=%0d expected 1/6", done_g, beat_cnt_g);
    end
  endtask

  task automatic test_reset_midrun();
    ready = 6'h3f; start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    checks++;
    if (valid !== 6'h04) begin errors++; $display("FAIL midrun_pending: got valid=%h expected 04", valid); end
    rst_n = 1'b0; ready = 6'h00; tick();
    checks++;
    if (valid !== 6'h00 || busy !== 1'b0 || done !== 1'b0 || beat_cnt !== 4'd0 || pay() !== 181'd0) begin
      errors++; $display("FAIL midrun_reset: got valid=%h busy=%b cnt=%0d expected 00/0/0", valid, busy, beat_cnt);
    end
    rst_n = 1'b1; ready = 6'h3f; start = 1'b1; tick(); start = 1'b0;
    tick();
    checks++;
    if (valid !== 6'h01 || pay() !== exp_beat(0)) begin
      errors++; $display("FAIL midrun_replay: got valid=%h addr=%h expected 01/00000", valid, address);
    end
    wait_done("midrun");
  endtask

  task automatic test_restart();
    int k;
    ready = 6'h3f; start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    checks++;
    if (valid !== 6'h08) begin errors++; $display("FAIL restart_beat3: got valid=%h expected 08", valid); end
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (valid !== 6'h10 || beat_cnt !== 4'd4 || busy !== 1'b1) begin
      errors++; $display("FAIL restart_busy_ignored: got valid=%h cnt=%0d expected 10/4", valid, beat_cnt);
    end
    wait_done("restart1");
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (done !== 1'b0 || beat_cnt !== 4'd0 || busy !== 1'b1 || valid !== 6'h00) begin
      errors++; $display("FAIL restart_done: got done=%b cnt=%0d busy=%b expected 0/0/1", done, beat_cnt, busy);
    end
    k = 0;
    while (valid !== 6'h20 && k < 32) begin tick(); k++; end
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (done !== 1'b1 || beat_cnt !== 4'd6) begin
      errors++; $display("FAIL last_accept_start: got done=%b cnt=%0d expected 1/6", done, beat_cnt);
    end
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL last_accept_hold: got done=%b busy=%b expected 1/0", done, busy);
    end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_stall();
    test_non_target();
    test_gap();
    test_reset_midrun();
    test_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
